// File: rtl/motor_drive_pwm.sv
// motor_drive_pwm: two-channel L298 IN1/IN2 + PWM driver with braked direction reversal.
// Optional MOTOR_RAMP_EN: soft-ramp duty after start/reversal; undefined drives straight to target.
module motor_drive_pwm #(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PRESC        = 196,
  parameter int unsigned DEADTIME_PER = 4,
  parameter int unsigned RAMP_STEP    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          directie_driverA,
  input  logic [1:0]          directie_driverB,
  input  logic [PWM_BITS-1:0] duty_a,
  input  logic [PWM_BITS-1:0] duty_b,
  output logic [1:0]          in_a,
  output logic                pwm_a,
  output logic [1:0]          in_b,
  output logic                pwm_b,
  output logic [1:0]          state_a,
  output logic [1:0]          state_b
);

  localparam int unsigned PS_W = $clog2(PRESC + 1);
  localparam int unsigned DT_W = $clog2(DEADTIME_PER + 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BRAKE = 2'd1,
    ST_RAMP  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

`ifdef MOTOR_RAMP_EN
  localparam state_e ST_START = ST_RAMP;
`else
  localparam state_e ST_START = ST_RUN;
`endif

  if (PRESC < 1 || DEADTIME_PER < 1 || RAMP_STEP < 1 || PWM_BITS < 2) begin : g_cfg_chk
    $error("motor_drive_pwm: invalid parameter set");
  end

  // Shared timebase: prescaler ticks drive a 0..2^PWM_BITS-2 period counter.
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                tick_c, period_end_c;
  logic                en_q;

  always_comb begin
    tick_c       = (presc_q == PS_W'(PRESC - 1));
    period_end_c = tick_c && (cnt_q == CNT_MAX);
    presc_d      = tick_c ? '0 : presc_q + PS_W'(1);
    cnt_d        = cnt_q;
    if (tick_c) begin
      cnt_d = period_end_c ? '0 : cnt_q + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      en_q    <= enable;
    end
  end

  logic [1:0]          dir_in   [2];
  logic [PWM_BITS-1:0] duty_in  [2];
  logic [1:0]          in_out   [2];
  logic [1:0]          st_out   [2];
  logic                pwm_out  [2];

  assign dir_in[0]  = directie_driverA;
  assign dir_in[1]  = directie_driverB;
  assign duty_in[0] = duty_a;
  assign duty_in[1] = duty_b;

  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [1:0]          dir_q, cur_dir_q, cur_dir_d, req_dir_q, req_dir_d;
    logic [1:0]          in_q, in_d;
    logic [PWM_BITS-1:0] tgt_q, duty_eff_q, duty_eff_d, start_duty_c;
    logic [DT_W-1:0]     dt_q, dt_d;
    logic                pwm_q, pwm_d, stop_c, rev_c;
`ifdef MOTOR_RAMP_EN
    logic [PWM_BITS:0]   ramp_sum_c;
`endif

    // Per-channel next state; outputs are derived from the next state so they register with it.
    always_comb begin
      state_d    = state_q;
      cur_dir_d  = cur_dir_q;
      req_dir_d  = req_dir_q;
      duty_eff_d = duty_eff_q;
      dt_d       = dt_q;
      stop_c     = !en_q || (dir_q == 2'b00) || (dir_q == 2'b11);
      rev_c      = (dir_q != cur_dir_q);
`ifdef MOTOR_RAMP_EN
      start_duty_c = '0;
      ramp_sum_c   = {1'b0, duty_eff_q} + (PWM_BITS + 1)'(RAMP_STEP);
`else
      start_duty_c = tgt_q;
`endif

      if (stop_c) begin
        state_d    = ST_IDLE;
        duty_eff_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rev_c && (cur_dir_q != 2'b00)) begin
              state_d   = ST_BRAKE;
              req_dir_d = dir_q;
              dt_d      = '0;
            end else begin
              state_d    = ST_START;
              cur_dir_d  = dir_q;
              duty_eff_d = start_duty_c;
            end
          end
          ST_BRAKE: begin
            req_dir_d = dir_q;
            if (period_end_c) begin
              dt_d = dt_q + DT_W'(1);
              if (dt_d == DT_W'(DEADTIME_PER)) begin
                state_d    = ST_START;
                cur_dir_d  = req_dir_d;
                duty_eff_d = start_duty_c;
              end
            end
          end
`ifdef MOTOR_RAMP_EN
          ST_RAMP: begin
            if (rev_c) begin
              state_d   = ST_BRAKE;
              req_dir_d = dir_q;
              dt_d      = '0;
            end else if (period_end_c) begin
              if (ramp_sum_c >= {1'b0, tgt_q}) begin
                duty_eff_d = tgt_q;
                state_d    = ST_RUN;
              end else begin
                duty_eff_d = ramp_sum_c[PWM_BITS-1:0];
              end
            end
          end
`endif
          ST_RUN: begin
            if (rev_c) begin
              state_d   = ST_BRAKE;
              req_dir_d = dir_q;
              dt_d      = '0;
            end else if (period_end_c) begin
              duty_eff_d = tgt_q;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      in_d  = 2'b00;
      pwm_d = 1'b0;
      case (state_d)
        ST_BRAKE: begin
          in_d  = 2'b11;
          pwm_d = 1'b1;
        end
        ST_RAMP, ST_RUN: begin
          in_d  = cur_dir_d;
          pwm_d = (cnt_d < duty_eff_d);
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        dir_q      <= '0;
        tgt_q      <= '0;
        cur_dir_q  <= '0;
        req_dir_q  <= '0;
        duty_eff_q <= '0;
        dt_q       <= '0;
        in_q       <= '0;
        pwm_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        dir_q      <= dir_in[c];
        tgt_q      <= duty_in[c];
        cur_dir_q  <= cur_dir_d;
        req_dir_q  <= req_dir_d;
        duty_eff_q <= duty_eff_d;
        dt_q       <= dt_d;
        in_q       <= in_d;
        pwm_q      <= pwm_d;
      end
    end

    assign in_out[c]  = in_q;
    assign pwm_out[c] = pwm_q;
    assign st_out[c]  = 2'(state_q);
  end

  assign in_a    = in_out[0];
  assign pwm_a   = pwm_out[0];
  assign state_a = st_out[0];
  assign in_b    = in_out[1];
  assign pwm_b   = pwm_out[1];
  assign state_b = st_out[1];

endmodule

// File: tb/tb_motor_drive_pwm.sv
// Directed bench for motor_drive_pwm (PRESC=2, DEADTIME_PER=2, RAMP_STEP=64, period 510 cycles).
module tb_motor_drive_pwm;

  localparam int unsigned PWM_BITS = 8;
  localparam int PERIOD = 510;
`ifdef MOTOR_RAMP_EN
  localparam int ST_GO = 2;
`else
  localparam int ST_GO = 3;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic [1:0]          dir_a = 2'b00, dir_b = 2'b00;
  logic [PWM_BITS-1:0] duty_a = '0, duty_b = '0;
  logic [1:0]          in_a, in_b, state_a, state_b;
  logic                pwm_a, pwm_b;

  int checks = 0;
  int failures = 0;
  int cyc;
  int ca, cb, e, p2;

  motor_drive_pwm #(
    .PWM_BITS(PWM_BITS), .PRESC(2), .DEADTIME_PER(2), .RAMP_STEP(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .directie_driverA(dir_a), .directie_driverB(dir_b),
    .duty_a(duty_a), .duty_b(duty_b),
    .in_a(in_a), .pwm_a(pwm_a), .in_b(in_b), .pwm_b(pwm_b),
    .state_a(state_a), .state_b(state_b)
  );

  always #5 clk = ~clk;

  // Reference timebase: edge k after reset release is a period end when k % 510 == 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_pe();
    int i;
    i = 0;
    do begin
      step(1);
      i++;
    end while ((cyc % PERIOD != 0) && (i < PERIOD));
  endtask

  task automatic count_hi(output int na, output int nb);
    na = 0;
    nb = 0;
    repeat (PERIOD) begin
      step(1);
      na += int'(pwm_a);
      nb += int'(pwm_b);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_a", int'(in_a), 0);
    check("rst_pwm_a", int'(pwm_a), 0);
    check("rst_state_a", int'(state_a), 0);
    check("rst_in_b", int'(in_b), 0);
    check("rst_pwm_b", int'(pwm_b), 0);
    check("rst_state_b", int'(state_b), 0);
    @(negedge clk) rst_n = 1'b1;
    step(2000);
    check("idle_in_a", int'(in_a), 0);
    check("idle_pwm_a", int'(pwm_a), 0);
    check("idle_state_a", int'(state_a), 0);
    check("idle_state_b", int'(state_b), 0);

    // Start both channels: A forward at 128, B reverse at 64.
    enable = 1'b1; dir_a = 2'b01; duty_a = 8'd128; dir_b = 2'b10; duty_b = 8'd64;
    step(1);
    check("lat_state_a", int'(state_a), 0);
    step(1);
    check("start_state_a", int'(state_a), ST_GO);
    check("start_in_a", int'(in_a), 1);
    check("start_state_b", int'(state_b), ST_GO);
    check("start_in_b", int'(in_b), 2);
`ifdef MOTOR_RAMP_EN
    check("start_pwm_a", int'(pwm_a), 0);
    to_pe();
    check("ramp64_state_a", int'(state_a), 2);
    to_pe();
    check("ramp128_state_a", int'(state_a), 3);
`endif
    count_hi(ca, cb);
    check("run_hi_a", ca, 256);
    check("run_hi_b", cb, 128);

    // Reversal from RUN: brake through two period ends, then drive the other way.
    step(100);
    dir_a = 2'b10;
    step(2);
    check("rev_in_a", int'(in_a), 3);
    check("rev_pwm_a", int'(pwm_a), 1);
    check("rev_state_a", int'(state_a), 1);
    e  = cyc;
    p2 = (e / PERIOD + 2) * PERIOD;
    while (cyc < p2 - 1) step(1);
    check("brake_hold_state_a", int'(state_a), 1);
    check("brake_hold_pwm_a", int'(pwm_a), 1);
    step(1);
    check("rev_done_state_a", int'(state_a), ST_GO);
    check("rev_done_in_a", int'(in_a), 2);
    check("rev_state_b", int'(state_b), 3);
    check("rev_in_b", int'(in_b), 2);
`ifdef MOTOR_RAMP_EN
    check("rev_ramp_pwm_a", int'(pwm_a), 0);
    to_pe();
    check("rev_ramp64_state_a", int'(state_a), 2);
    to_pe();
    check("rev_ramp128_state_a", int'(state_a), 3);
`endif
    count_hi(ca, cb);
    check("rev_hi_a", ca, 256);
    check("rev_hi_b", cb, 128);

    // Duty changes in RUN only take effect at the next period end.
    step(300);
    duty_a = 8'd255;
    while (cyc % PERIOD != PERIOD - 1) step(1);
    check("duty255_hold_pwm_a", int'(pwm_a), 0);
    step(1);
    count_hi(ca, cb);
    check("duty255_hi_a", ca, PERIOD);
    duty_a = 8'd0;
    step(300);
    check("duty0_hold_mid_pwm_a", int'(pwm_a), 1);
    while (cyc % PERIOD != PERIOD - 1) step(1);
    check("duty0_hold_end_pwm_a", int'(pwm_a), 1);
    step(1);
    count_hi(ca, cb);
    check("duty0_hi_a", ca, 0);

    // Asynchronous reset in the middle of a brake.
    duty_a = 8'd128; dir_a = 2'b01;
    step(2);
    check("pre_rst_state_a", int'(state_a), 1);
    step(40);
    rst_n = 1'b0;
    #1;
    check("arst_in_a", int'(in_a), 0);
    check("arst_pwm_a", int'(pwm_a), 0);
    check("arst_state_a", int'(state_a), 0);
    check("arst_in_b", int'(in_b), 0);
    check("arst_state_b", int'(state_b), 0);
    step(2);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rel_state_a", int'(state_a), 0);
    step(1);
    check("rel1_state_a", int'(state_a), 0);
    step(1);
    check("rel2_state_a", int'(state_a), ST_GO);
    check("rel2_in_a", int'(in_a), 1);
    check("rel2_state_b", int'(state_b), ST_GO);

    // Stop, resume in the same direction, reverse from IDLE, and stop overriding a brake.
    dir_a = 2'b00;
    step(2);
    check("stop_state_a", int'(state_a), 0);
    check("stop_in_a", int'(in_a), 0);
    check("stop_pwm_a", int'(pwm_a), 0);
    check("stop_state_b", int'(state_b), ST_GO);
    dir_a = 2'b01;
    step(2);
    check("resume_state_a", int'(state_a), ST_GO);
    check("resume_in_a", int'(in_a), 1);
    dir_a = 2'b00;
    step(2);
    dir_a = 2'b10;
    step(2);
    check("idle_rev_state_a", int'(state_a), 1);
    check("idle_rev_in_a", int'(in_a), 3);
    dir_a = 2'b11;
    step(2);
    check("stop11_state_a", int'(state_a), 0);
    check("stop11_in_a", int'(in_a), 0);
    enable = 1'b0;
    step(2);
    check("dis_state_b", int'(state_b), 0);
    check("dis_in_b", int'(in_b), 0);
    check("dis_pwm_b", int'(pwm_b), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
